// File: rtl/plab4_net_router_input_term_ctrl_tdm.sv
`default_nettype none
// Ring-router input-terminal control with TDM domain isolation: routes the head
// packet and requests the switch only inside the owning domain's time slot.
module plab4_net_router_input_term_ctrl_tdm #(
  parameter int p_router_id      = 0,
  parameter int p_num_routers    = 8,
  parameter int p_num_free_nbits = 2,
  parameter int p_min_free       = 2,
  parameter int p_num_domains    = 2,
  parameter int p_slot_len       = 8,
  parameter int p_dead_cycles    = 1,
  localparam int c_dest_nbits = $clog2(p_num_routers),
  localparam int c_dom_nbits  = (p_num_domains > 1) ? $clog2(p_num_domains) : 1,
  localparam int c_slot_nbits = (p_slot_len > 1) ? $clog2(p_slot_len) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [c_dom_nbits-1:0]      domain_ID,
  input  logic [c_dest_nbits-1:0]     dest,
  input  logic                        in_val,
  output logic                        in_rdy,
  input  logic [p_num_free_nbits-1:0] num_free_west,
  input  logic [p_num_free_nbits-1:0] num_free_east,
  output logic [2:0]                  reqs,
  input  logic [2:0]                  grants,
  output logic [c_dom_nbits-1:0]      cur_domain,
  output logic [c_slot_nbits-1:0]     slot_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam logic [2:0] c_route_prev = 3'b001;
  localparam logic [2:0] c_route_term = 3'b010;
  localparam logic [2:0] c_route_next = 3'b100;

  localparam logic [c_slot_nbits-1:0] c_slot_last = c_slot_nbits'(p_slot_len - 1);
  localparam logic [c_dom_nbits-1:0]  c_dom_last  = c_dom_nbits'(p_num_domains - 1);

  state_t                 state;
  logic [2:0]             route_q;
  logic [c_dom_nbits-1:0] domain_q;
  logic [2:0]             route_d;
  logic [31:0]            route_sum;
  logic [31:0]            route_dist;
  logic                   slot_open;
  logic                   slot_last;
  logic                   accept;
  logic                   west_ok;
  logic                   east_ok;

  // Slot/domain schedule: free-running, independent of any traffic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt   <= '0;
      cur_domain <= '0;
    end else if (slot_cnt == c_slot_last) begin
      slot_cnt   <= '0;
      cur_domain <= (cur_domain == c_dom_last) ? '0 : cur_domain + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  assign slot_open = 32'(slot_cnt) < 32'(p_slot_len - p_dead_cycles);
  assign slot_last = (slot_cnt == c_slot_last);

  // dest and router id are both below p_num_routers, so one conditional subtract
  // yields the forward ring distance.
  assign route_sum  = 32'(dest) + 32'(p_num_routers - p_router_id);
  assign route_dist = (route_sum >= 32'(p_num_routers)) ? route_sum - 32'(p_num_routers)
                                                         : route_sum;

  always_comb begin
    route_d = c_route_prev;
    if (route_dist == 32'd0) begin
      route_d = c_route_term;
    end else if (route_dist <= 32'(p_num_routers / 2)) begin
      route_d = c_route_next;
    end
  end

  assign accept  = in_val && (domain_ID == cur_domain) && slot_open;
  assign west_ok = 32'(num_free_west) >= 32'(p_min_free);
  assign east_ok = 32'(num_free_east) >= 32'(p_min_free);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      route_q  <= '0;
      domain_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= REQ;
            route_q  <= route_d;
            domain_q <= domain_ID;
          end
        end
        REQ: begin
          // An unserved request is withdrawn at slot end; the packet retries later.
          if (in_rdy || slot_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    reqs = 3'b000;
    if ((state == REQ) && (domain_q == cur_domain)) begin
      case (route_q)
        c_route_term: reqs = c_route_term;
        c_route_next: reqs = west_ok ? c_route_next : 3'b000;
        c_route_prev: reqs = east_ok ? c_route_prev : 3'b000;
        default:      reqs = 3'b000;
      endcase
    end
  end

  assign in_rdy = |(reqs & grants);

endmodule
`default_nettype wire

// File: doc/plab4_net_router_input_term_ctrl_tdm.md
PLAB4_NET_ROUTER_INPUT_TERM_CTRL_TDM -- requirements
Module: plab4_net_router_input_term_ctrl_tdm

Interface
REQ-001 Parameter p_router_id, default 0: ring position of this router.
REQ-002 Parameter p_num_routers, default 8: routers on ring, ≥2.
REQ-003 Parameter p_num_free_nbits, default 2: width of neighbour free-slot counts.
REQ-004 Parameter p_min_free, default 2: minimum downstream free slots to request PREV/NEXT.
REQ-005 Parameter p_num_domains, default 2: security domains in TDM schedule, ≥1.
REQ-006 Parameter p_slot_len, default 8: cycles per domain slot, ≥2.
REQ-007 Parameter p_dead_cycles, default 1: final cycles of each slot in which no new request starts, < p_slot_len.
REQ-008 Derived: c_dest_nbits = $clog2(p_num_routers); c_dom_nbits = max(1,$clog2(p_num_domains)); c_slot_nbits = max(1,$clog2(p_slot_len)).
REQ-009 clk  in  1  sole clock, rising edge.
REQ-010 reset  in  1  asynchronous, active-low reset.
REQ-011 domain_ID  in  c_dom_nbits  domain of head packet.
REQ-012 dest  in  c_dest_nbits  destination router of head packet.
REQ-013 in_val  in  1  head packet valid.
REQ-014 in_rdy  out  1  head packet consumed this cycle.
REQ-015 num_free_west  in  p_num_free_nbits  free slots, NEXT-direction queue.
REQ-016 num_free_east  in  p_num_free_nbits  free slots, PREV-direction queue.
REQ-017 reqs  out  3  one-hot request: bit0 PREV, bit1 TERM, bit2 NEXT.
REQ-018 grants  in  3  switch-allocator grants, same encoding.
REQ-019 cur_domain  out  c_dom_nbits  domain owning current slot.
REQ-020 slot_cnt  out  c_slot_nbits  cycle index within current slot.

Function
REQ-021 Route: d = (dest − p_router_id) mod p_num_routers; d==0 → TERM; 0<d≤p_num_routers/2 (integer) → NEXT; else → PREV.
REQ-022 Schedule: slot_cnt increments each cycle; at p_slot_len−1 wraps to 0 and cur_domain advances, wrapping p_num_domains−1 → 0.
REQ-023 open = (slot_cnt < p_slot_len − p_dead_cycles); last = (slot_cnt == p_slot_len−1).
REQ-024 FSM states IDLE, REQ; REQ holds a registered route and registered domain.
REQ-025 IDLE → REQ when in_val & (domain_ID==cur_domain) & open; route and domain latched same edge.
REQ-026 REQ → IDLE on in_rdy, or on last without in_rdy (request withdrawn, packet retried in a later own-domain slot).
REQ-027 reqs = 0 in IDLE; in REQ: TERM → 3'b010; NEXT → 3'b100 iff num_free_west ≥ p_min_free, else 0; PREV → 3'b001 iff num_free_east ≥ p_min_free, else 0; credit check combinational every cycle.
REQ-028 in_rdy = |(reqs & grants); combinational, asserts only in REQ.
REQ-029 First request appears the cycle after acceptance (one-cycle latency); earliest in_rdy same cycle as first reqs.
REQ-030 in_val dropping while in REQ: reqs held (head-of-line packet assumed stable until in_rdy).
REQ-031 Grants on bits not in reqs are ignored.
REQ-032 No output depends on another domain's traffic or credits outside that domain's slot.

Reset
REQ-033 reset low: state IDLE, slot_cnt 0, cur_domain 0, reqs 0, in_rdy 0, latched route/domain 0; asynchronous, mid-request reset drops request immediately.
REQ-034 First slot after reset release belongs to domain 0, starting slot_cnt 0.

Verification
REQ-035 Defaults, id 0, dest 0, domain 0, in_val at slot_cnt 0 → reqs 3'b010 at slot_cnt 1; grants 3'b010 → in_rdy 1, IDLE next.
REQ-036 id 0, dest 3, num_free_west 1 → reqs 0 through slot; west rises to 2 at slot_cnt 5 → reqs 3'b100 same cycle.
REQ-037 dest 5 (d=5) domain 0, never granted → reqs 3'b001 slot_cnt 1..7, 0 at slot_cnt 0 of domain-1 slot; re-requested at domain-0 slot_cnt 1.
REQ-038 domain_ID 1 in_val during domain-0 slot → reqs 0 until cur_domain 1, then request at slot_cnt 1.
REQ-039 in_val arriving at slot_cnt 7 (dead cycle) → no request; request starts next own-domain slot.
REQ-040 reset low while reqs 3'b100 → reqs 0, slot_cnt 0, cur_domain 0 without clock edge.
